// File: rtl/ctrl_pkg.sv
// Shared definitions for the down-sampling processor control unit and its ALU:
// opcode map, ALU command codes, B-bus memory-data select and FSM state encoding.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_MUL   = 4'h3;
  localparam logic [3:0] OP_DIV   = 4'h4;
  localparam logic [3:0] OP_MOVE  = 4'h5;
  localparam logic [3:0] OP_LDAC  = 4'h6;
  localparam logic [3:0] OP_INC   = 4'h7;
  localparam logic [3:0] OP_DEC   = 4'h8;
  localparam logic [3:0] OP_CLAC  = 4'h9;
  localparam logic [3:0] OP_LOAD  = 4'hA;
  localparam logic [3:0] OP_STORE = 4'hB;
  localparam logic [3:0] OP_JUMP  = 4'hC;
  localparam logic [3:0] OP_JPNZ  = 4'hD;
  localparam logic [3:0] OP_JPZ   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [3:0] ALU_HOLD = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_MUL  = 4'b0011;
  localparam logic [3:0] ALU_DIV  = 4'b0100;
  localparam logic [3:0] ALU_MOVE = 4'b0101;
  localparam logic [3:0] ALU_LDAC = 4'b0110;
  localparam logic [3:0] ALU_INC  = 4'b0111;
  localparam logic [3:0] ALU_DEC  = 4'b1000;
  localparam logic [3:0] ALU_CLR  = 4'b1001;

  localparam logic [3:0] B_SEL_MDR = 4'hF;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_FWAIT,
    ST_LOADIR,
    ST_DECODE,
    ST_DWAIT,
    ST_EXEC,
    ST_STORE,
    ST_JUMP,
    ST_HALT
  } state_t;

  // Opcodes whose register operand drives the B bus during DECODE and EXEC.
  function automatic logic usesBReg(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
           (op == OP_DIV) || (op == OP_MOVE);
  endfunction

  function automatic logic [3:0] aluFor(input logic [3:0] op);
    logic [3:0] code;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_MUL:  code = ALU_MUL;
      OP_DIV:  code = ALU_DIV;
      OP_MOVE: code = ALU_MOVE;
      OP_LDAC: code = ALU_LDAC;
      OP_INC:  code = ALU_INC;
      OP_DEC:  code = ALU_DEC;
      OP_CLAC: code = ALU_CLR;
      default: code = ALU_HOLD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Loadable 4-bit down-counter that sticks at zero; done flags the final wait cycle.
module ctrl_wait_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] value,
  output logic       done
);

  logic [3:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= 4'd0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != 4'd0) begin
      count_q <= count_q - 4'd1;
    end
  end

  assign done = (count_q == 4'd0);

endmodule

// File: rtl/instr_decode_ctrl.sv
// Fetch/decode control unit issuing ALU commands, bus selects and PC/IR/memory strobes.
// Build option HW_MULDIV_EN: when defined MUL/DIV issue ALU codes, otherwise they run as NOP and flag illegal_op.
module instr_decode_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        Z_in,
  output logic [3:0]  ALU_control,
  output logic [3:0]  B_sel,
  output logic        addr_sel,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        halted,
  output logic        illegal_op
);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_badLatency
      $error("instr_decode_ctrl: MEM_LAT must be in 1..15");
    end
  endgenerate

  // Timer counts down to zero, so each wait state lasts (load value + 1) cycles.
  localparam logic [3:0] FWAIT_LOAD = (MEM_LAT >= 2) ? 4'(MEM_LAT - 2) : 4'd0;
  localparam logic [3:0] DWAIT_LOAD = 4'(MEM_LAT - 1);

  state_t     state_q, state_d;
  logic       run_q;
  logic [3:0] aluCode_q, aluCode_d;
  logic       illegal_q, illegal_d;
  logic       taken_q, taken_d;
  logic       timerLoad;
  logic [3:0] timerValue;
  logic       timerDone;
  logic [3:0] op;
  logic       unusedBits;

  assign op         = instr[15:12];
  assign unusedBits = ^instr[11:4];

  ctrl_wait_timer u_waitTimer (
    .clock (clock),
    .reset (reset),
    .load  (timerLoad),
    .value (timerValue),
    .done  (timerDone)
  );

  // run_q holds off the first fetch for one cycle so everything reads 0 right after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      run_q     <= 1'b0;
      aluCode_q <= ALU_HOLD;
      illegal_q <= 1'b0;
      taken_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      aluCode_q <= aluCode_d;
      illegal_q <= illegal_d;
      taken_q   <= taken_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    aluCode_d  = aluCode_q;
    illegal_d  = illegal_q;
    taken_d    = taken_q;
    timerLoad  = 1'b0;
    timerValue = FWAIT_LOAD;
    case (state_q)
      ST_FETCH: begin
        if (run_q) begin
          if (MEM_LAT == 1) begin
            state_d = ST_LOADIR;
          end else begin
            timerLoad = 1'b1;
            state_d   = ST_FWAIT;
          end
        end
      end
      ST_FWAIT:  if (timerDone) state_d = ST_LOADIR;
      ST_LOADIR: state_d = ST_DECODE;
      ST_DECODE: begin
        // Capture the command and branch decision so EXEC/JUMP outputs come from registers.
        aluCode_d = aluFor(op);
        illegal_d = 1'b0;
        taken_d   = 1'b0;
        case (op)
          OP_MUL, OP_DIV: begin
`ifdef HW_MULDIV_EN
            aluCode_d = aluFor(op);
`else
            aluCode_d = ALU_HOLD;
            illegal_d = 1'b1;
`endif
            state_d = ST_EXEC;
          end
          OP_LOAD: begin
            aluCode_d  = ALU_MOVE;
            timerLoad  = 1'b1;
            timerValue = DWAIT_LOAD;
            state_d    = ST_DWAIT;
          end
          OP_STORE: state_d = ST_STORE;
          OP_JUMP: begin
            taken_d = 1'b1;
            state_d = ST_JUMP;
          end
          OP_JPNZ: begin
            taken_d = ~Z_in;
            state_d = ST_JUMP;
          end
          OP_JPZ: begin
            taken_d = Z_in;
            state_d = ST_JUMP;
          end
          OP_HALT: state_d = ST_HALT;
          default: state_d = ST_EXEC;
        endcase
      end
      ST_DWAIT: if (timerDone) state_d = ST_EXEC;
      ST_EXEC, ST_STORE, ST_JUMP: state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    B_sel = 4'h0;
    if ((state_q == ST_DECODE || state_q == ST_EXEC) && usesBReg(op)) begin
      B_sel = instr[3:0];
    end else if (state_q == ST_EXEC && op == OP_LOAD) begin
      B_sel = B_SEL_MDR;
    end
  end

  assign ALU_control = (state_q == ST_EXEC) ? aluCode_q : ALU_HOLD;
  assign illegal_op  = (state_q == ST_EXEC) && illegal_q;
  assign mem_rd      = (state_q == ST_FETCH && run_q) || (state_q == ST_FWAIT) ||
                       (state_q == ST_DWAIT);
  assign addr_sel    = (state_q == ST_DWAIT) || (state_q == ST_STORE);
  assign mem_wr      = (state_q == ST_STORE);
  assign ir_load     = (state_q == ST_LOADIR);
  assign pc_inc      = (state_q == ST_LOADIR);
  assign pc_load     = (state_q == ST_JUMP) && taken_q;
  assign halted      = (state_q == ST_HALT);

endmodule
